ara_vrt_profiler: RTL

//  Sequences Ara vector-runtime measurement: arms on the SW counter enable, starts counting on the

---
 rtl/ara_vrt_profiler.sv | 191 +++++++++++++++++++
 1 files changed

// File: rtl/ara_vrt_profiler.sv
// Ara vector-runtime profiler: arms on the SW enable, counts from the first dispatched request and
// snapshots counters whenever Ara drains. Stall counters exist only when ARA_VRT_STALL_CNT_EN is defined.
module ara_vrt_profiler #(
    parameter int unsigned CntWidth  = 64,
    parameter int unsigned AddrWidth = 3
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,
    input  logic                 cnt_en_i,
    input  logic                 acc_req_valid_i,
    input  logic                 ara_idle_i,
    input  logic                 dcache_miss_i,
    input  logic                 icache_miss_i,
    input  logic                 sb_full_i,
    input  logic                 cfg_req_i,
    input  logic                 cfg_we_i,
    input  logic [AddrWidth-1:0] cfg_addr_i,
    input  logic [CntWidth-1:0]  cfg_wdata_i,
    output logic [CntWidth-1:0]  cfg_rdata_o,
    output logic                 cfg_rvalid_o,
    output logic                 running_o,
    output logic                 snap_valid_o
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ARMED = 2'd1,
        RUN   = 2'd2,
        DRAIN = 2'd3
    } state_e;

    state_e               state_q;
    logic [CntWidth-1:0]  runtime_q;
    logic [CntWidth-1:0]  runtime_d;
    logic [CntWidth-1:0]  runtime_buf_q;
    logic                 pending_q;
    logic [7:0]           snap_cnt_q;
    logic                 snap_valid_q;
    logic                 running;
    logic                 pending_set;
    logic                 snap_take;
    logic                 clear_fire;
    logic [15:0]          status;
    logic [CntWidth-1:0]  status_word;
    logic [CntWidth-1:0]  rdata_d;

    function automatic logic [CntWidth-1:0] sat_inc(input logic [CntWidth-1:0] v, input logic en);
        if (en && (v != {CntWidth{1'b1}})) begin
            return v + CntWidth'(1);
        end
        return v;
    endfunction

    assign running     = (state_q == RUN) || (state_q == DRAIN);
    assign pending_set = acc_req_valid_i && (running || ((state_q == ARMED) && cnt_en_i));
    assign snap_take   = pending_q && ara_idle_i && !acc_req_valid_i && !pending_set;
    assign clear_fire  = cfg_req_i && cfg_we_i && (cfg_addr_i == AddrWidth'(5)) && (state_q == IDLE);
    // A snapshot captures the counters including the snapshot cycle itself.
    assign runtime_d   = sat_inc(runtime_q, running);

    assign running_o    = running;
    assign snap_valid_o = snap_valid_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= IDLE;
        end else begin
            case (state_q)
                IDLE: begin
                    if (cnt_en_i) state_q <= ARMED;
                end
                ARMED: begin
                    if (!cnt_en_i)            state_q <= IDLE;
                    else if (acc_req_valid_i) state_q <= RUN;
                end
                RUN: begin
                    if (!cnt_en_i) state_q <= DRAIN;
                end
                DRAIN: begin
                    if (cnt_en_i)        state_q <= RUN;
                    else if (ara_idle_i) state_q <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            runtime_q     <= '0;
            runtime_buf_q <= '0;
            pending_q     <= 1'b0;
            snap_cnt_q    <= 8'd0;
            snap_valid_q  <= 1'b0;
        end else if (clear_fire) begin
            runtime_q     <= '0;
            runtime_buf_q <= '0;
            pending_q     <= 1'b0;
            snap_cnt_q    <= 8'd0;
            snap_valid_q  <= 1'b0;
        end else begin
            runtime_q <= runtime_d;
            if (pending_set) begin
                pending_q <= 1'b1;
            end else if (snap_take) begin
                runtime_buf_q <= runtime_d;
                pending_q     <= 1'b0;
                snap_cnt_q    <= snap_cnt_q + 8'd1;
                snap_valid_q  <= 1'b1;
            end
        end
    end

`ifdef ARA_VRT_STALL_CNT_EN
    logic [CntWidth-1:0] dcache_q, icache_q, sbfull_q;
    logic [CntWidth-1:0] dcache_d, icache_d, sbfull_d;
    logic [CntWidth-1:0] dcache_buf_q, icache_buf_q, sbfull_buf_q;
    logic                unused_inputs;

    assign dcache_d = sat_inc(dcache_q, running && dcache_miss_i);
    assign icache_d = sat_inc(icache_q, running && icache_miss_i);
    assign sbfull_d = sat_inc(sbfull_q, running && sb_full_i);
    assign unused_inputs = ^cfg_wdata_i;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            dcache_q     <= '0;
            icache_q     <= '0;
            sbfull_q     <= '0;
            dcache_buf_q <= '0;
            icache_buf_q <= '0;
            sbfull_buf_q <= '0;
        end else if (clear_fire) begin
            dcache_q     <= '0;
            icache_q     <= '0;
            sbfull_q     <= '0;
            dcache_buf_q <= '0;
            icache_buf_q <= '0;
            sbfull_buf_q <= '0;
        end else begin
            dcache_q <= dcache_d;
            icache_q <= icache_d;
            sbfull_q <= sbfull_d;
            if (snap_take) begin
                dcache_buf_q <= dcache_d;
                icache_buf_q <= icache_d;
                sbfull_buf_q <= sbfull_d;
            end
        end
    end
`else
    logic unused_inputs;
    assign unused_inputs = ^{cfg_wdata_i, dcache_miss_i, icache_miss_i, sb_full_i};
`endif

    assign status = {snap_cnt_q, 3'b000, pending_q, 2'b00, state_q};

    // STATUS is zero-extended, or truncated for narrow counter builds.
    generate
        if (CntWidth > 16) begin : g_status_wide
            assign status_word = {{(CntWidth-16){1'b0}}, status};
        end else begin : g_status_narrow
            assign status_word = status[CntWidth-1:0];
        end
    endgenerate

    always_comb begin
        rdata_d = '0;
        case (cfg_addr_i)
            AddrWidth'(0): rdata_d = status_word;
            AddrWidth'(1): rdata_d = runtime_buf_q;
`ifdef ARA_VRT_STALL_CNT_EN
            AddrWidth'(2): rdata_d = dcache_buf_q;
            AddrWidth'(3): rdata_d = icache_buf_q;
            AddrWidth'(4): rdata_d = sbfull_buf_q;
`endif
            default:       rdata_d = '0;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cfg_rvalid_o <= 1'b0;
            cfg_rdata_o  <= '0;
        end else begin
            cfg_rvalid_o <= cfg_req_i;
            cfg_rdata_o  <= (cfg_req_i && !cfg_we_i) ? rdata_d : '0;
        end
    end

endmodule
